// File: rtl/msk_round_sequencer.sv
// Round/stage/glitch-window strobe sequencer for masked round-based ciphers; MSK_SEQ_CLEAR_EN adds a one-cycle CLEAR state.
// Latency: done NROUNDS*CYC_PER_ROUND cycles after start, plus one cycle per stall; all strobes are Mealy.
// Backpressure: rnd_valid low on a stage cycle holds both counters; cycle 0 and the round-boundary cycle never stall.
module msk_round_sequencer #(
    parameter int D             = 2,
    parameter int NROUNDS       = 40,
    parameter int CYC_PER_ROUND = 6,
    parameter int GLITCH_CYC    = 4,
    localparam int RW   = ($clog2(NROUNDS) < 1) ? 1 : $clog2(NROUNDS),
    localparam int CW   = ($clog2(CYC_PER_ROUND) < 1) ? 1 : $clog2(CYC_PER_ROUND),
    localparam int NSTG = CYC_PER_ROUND - 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    input  logic            rnd_valid,
    output logic            rnd_ready,
    output logic            load,
    output logic            round_start,
    output logic [NSTG-1:0] stage_en,
    output logic            glitch_en,
    output logic            last_round,
    output logic [RW-1:0]   round_idx,
    output logic            busy,
    output logic            done,
    output logic            aborted,
    output logic            clear
);

    if (D < 1) begin : g_bad_d
        $error("msk_round_sequencer: D must be >= 1");
    end
    if (NROUNDS < 1) begin : g_bad_nrounds
        $error("msk_round_sequencer: NROUNDS must be >= 1");
    end
    if (CYC_PER_ROUND < 3) begin : g_bad_cpr
        $error("msk_round_sequencer: CYC_PER_ROUND must be >= 3");
    end
    if (GLITCH_CYC < 1 || GLITCH_CYC > CYC_PER_ROUND - 2) begin : g_bad_glitch
        $error("msk_round_sequencer: GLITCH_CYC out of range");
    end

    localparam logic [RW-1:0] RND_LAST = RW'(NROUNDS - 1);
    localparam logic [CW-1:0] CYC_LAST = CW'(CYC_PER_ROUND - 1);
    localparam logic [CW-1:0] CYC_GLT  = CW'(GLITCH_CYC);

`ifdef MSK_SEQ_CLEAR_EN
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, CLEAR = 2'd2} state_e;
    localparam state_e ST_AFTER = CLEAR;
`else
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;
    localparam state_e ST_AFTER = IDLE;
`endif

    state_e          state_q, state_d;
    logic [RW-1:0]   round_cnt_q, round_cnt_d;
    logic [CW-1:0]   cyc_cnt_q, cyc_cnt_d;
    logic            stage_act;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            round_cnt_q <= '0;
            cyc_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            round_cnt_q <= round_cnt_d;
            cyc_cnt_q   <= cyc_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        round_cnt_d = round_cnt_q;
        cyc_cnt_d   = cyc_cnt_q;
        stage_act   = 1'b0;
        rnd_ready   = 1'b0;
        load        = 1'b0;
        round_start = 1'b0;
        glitch_en   = 1'b0;
        last_round  = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        aborted     = 1'b0;
        clear       = 1'b0;
        round_idx   = round_cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    load        = 1'b1;
                    round_start = 1'b1;
                    round_cnt_d = '0;
                    cyc_cnt_d   = '0;
                    state_d     = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (abort) begin
                    // abort outranks everything, including the final-cycle done
                    aborted     = 1'b1;
                    round_cnt_d = '0;
                    cyc_cnt_d   = '0;
                    state_d     = ST_AFTER;
                end else begin
                    last_round = (round_cnt_q == RND_LAST);
                    if (cyc_cnt_q == '0) begin
                        cyc_cnt_d = cyc_cnt_q + CW'(1);
                    end else if (cyc_cnt_q == CYC_LAST) begin
                        round_start = 1'b1;
                        cyc_cnt_d   = '0;
                        if (round_cnt_q == RND_LAST) begin
                            done        = 1'b1;
                            load        = 1'b1;
                            round_cnt_d = '0;
                            state_d     = ST_AFTER;
                        end else begin
                            round_cnt_d = round_cnt_q + RW'(1);
                        end
                    end else if (rnd_valid) begin
                        stage_act = 1'b1;
                        rnd_ready = 1'b1;
                        glitch_en = (cyc_cnt_q == CYC_GLT);
                        cyc_cnt_d = cyc_cnt_q + CW'(1);
                    end
                end
            end
`ifdef MSK_SEQ_CLEAR_EN
            CLEAR: begin
                busy    = 1'b1;
                clear   = 1'b1;
                state_d = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // stage k is enabled on cycle k+1 of the round
    always_comb begin
        for (int i = 0; i < NSTG; i++) begin
            stage_en[i] = stage_act && (cyc_cnt_q == CW'(i + 1));
        end
    end

    a_stage_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(stage_en));
    a_done_xor_abort: assert property (@(posedge clk) disable iff (reset) !(done && aborted));
    a_cyc_range: assert property (@(posedge clk) disable iff (reset) cyc_cnt_q <= CYC_LAST);
    a_rnd_range: assert property (@(posedge clk) disable iff (reset) round_cnt_q <= RND_LAST);

endmodule

// File: doc/msk_round_sequencer.md
Name: msk_round_sequencer

Overview:
- Parametrised control FSM for masked, round-based block ciphers such as masked SKINNY with borrowed-time glitch handling.
- Generates per-round load, stage and glitch-window strobes for a datapath that spends a fixed number of cycles per round.
- Generalises round count, cycles per round and glitch-window position.
- Adds a randomness-availability stall, a start/busy/done handshake, an abort, and optional post-run share zeroisation.

Parameters:
- D, 2: masking share count; pass-through only, no effect on control timing.
- NROUNDS, 40: rounds per encryption; must be >= 1.
- CYC_PER_ROUND, 6: cycles per round; must be >= 3.
- GLITCH_CYC, 4: cycle index within a round at which glitch_en fires; must satisfy 1 <= GLITCH_CYC <= CYC_PER_ROUND-2.
- Localparams: RW = max(1, clog2(NROUNDS)); CW = max(1, clog2(CYC_PER_ROUND)); NSTG = CYC_PER_ROUND-2.

Ports:
- clk, input, 1: clock.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: request encryption; sampled only in IDLE.
- abort, input, 1: terminate a run in progress.
- rnd_valid, input, 1: fresh masking randomness available this cycle.
- rnd_ready, output, 1: randomness consumed this cycle.
- load, output, 1: select plaintext/key inputs into the state register.
- round_start, output, 1: state-register enable at a round boundary.
- stage_en, output, NSTG: one-hot pipeline-stage enables.
- glitch_en, output, 1: borrowed-time glitch-window enable.
- last_round, output, 1: high throughout the final round.
- round_idx, output, RW: current round number.
- busy, output, 1: high in any state other than IDLE.
- done, output, 1: one-cycle pulse on completion.
- aborted, output, 1: one-cycle pulse on abort.
- clear, output, 1: share-zeroisation pulse (see Optional Feature).

Behaviour:
- Clocking and reset:
  - Clock clk; reset reset, synchronous, active-high.
  - Reset forces state=IDLE and round_cnt=cyc_cnt=0.
  - Reset has priority over abort and start.
- Output timing:
  - All strobes are Mealy (combinational from state, counters and inputs).
  - After reset with start=0, every output is 0 and round_idx=0.
- States: IDLE, RUN, plus CLEAR when the optional feature is enabled.
- IDLE:
  - busy=0.
  - On start=1: load=1 and round_start=1 in the same cycle; round_cnt<=0, cyc_cnt<=0; go to RUN.
- RUN, general rules:
  - busy=1; round_idx=round_cnt.
  - last_round = (round_cnt == NROUNDS-1).
  - start is ignored.
- RUN, stage cycles (1 <= cyc_cnt <= CYC_PER_ROUND-2):
  - If rnd_valid=1: stage_en[cyc_cnt-1]=1 and rnd_ready=1; glitch_en=1 when cyc_cnt==GLITCH_CYC; cyc_cnt increments.
  - If rnd_valid=0 (stall): no strobes; both counters hold.
- RUN, cycle 0: no strobes; cyc_cnt increments unconditionally.
- RUN, cycle CYC_PER_ROUND-1 (never stalls):
  - round_start=1; cyc_cnt<=0.
  - If round_cnt < NROUNDS-1: round_cnt increments.
  - If round_cnt == NROUNDS-1: done=1 and load=1 (the output register captures the final state); round_cnt<=0; go to IDLE, or CLEAR when enabled.
- Latency: with no stalls, start accepted at cycle T gives done at cycle T + NROUNDS*CYC_PER_ROUND. Each stall cycle adds 1.
- Abort:
  - abort=1 in RUN: aborted=1; no other strobes, done=0; counters reset to 0; go to IDLE, or CLEAR when enabled.
  - abort is ignored in IDLE and in CLEAR.
  - abort wins over a simultaneous final-cycle done.
- Counter wrap: counters never exceed NROUNDS-1 and CYC_PER_ROUND-1.

Optional Feature:
- Macro: MSK_SEQ_CLEAR_EN.
- Defined:
  - After done or aborted, the FSM spends exactly one cycle in CLEAR with clear=1 and busy=1; start is ignored in that cycle.
  - The FSM then returns to IDLE.
  - clear drives the borrowed-time share zeroisation in the datapath.
- Undefined:
  - clear is tied to 0 and the CLEAR state does not exist.
  - done and aborted return the FSM directly to IDLE.
  - Back-to-back start is accepted in the cycle immediately after done.

Test Plan:
- Default parameters, rnd_valid=1, start pulse at cycle 0 -> load and round_start at 0; done at cycle 240; round_start asserted 41 times; stage_en[0..3] each 40 times; glitch_en 40 times at cyc 4; last_round high for cycles 235-240.
- rnd_valid low for 3 cycles while in round 5 at cyc 2 -> no strobes during the stall; stage_en[1] fires on the first valid cycle; done moves to 243; rnd_ready count = 160.
- abort at cycle 100 -> aborted pulse at 100; no done; busy drops at 101 (102 with MSK_SEQ_CLEAR_EN, which also gives clear=1 at 101); a new start at 102 restarts from round 0.
- Final-cycle corner: abort and the final cycle coincide -> aborted=1, done=0. reset asserted mid-run at cycle 50 -> all outputs 0 from cycle 51, round_idx=0.
- NROUNDS=4, CYC_PER_ROUND=3, GLITCH_CYC=1 -> done at cycle 12; stage_en width 1; glitch_en coincides with stage_en[0]. With MSK_SEQ_CLEAR_EN: clear at 13, start at 13 ignored, start at 14 accepted.
- start held high continuously (no MSK_SEQ_CLEAR_EN) -> runs back-to-back; each done is followed by load/round_start of the next run in the next cycle; no start is accepted while busy.
